// File: rtl/divider_8bit_if.sv
// Operand/result bundle for divider_8bit.
//   Load_Divisor, Run, S      : control levels and switch data into the divider
//   Qval, Rval, Dval          : signed quotient, signed remainder, stored divisor
//   Busy, Done                : division in progress / results valid while Run held
//   Div_Zero, Overflow        : status of the last division
//   QhexL/QhexU/RhexL/RhexU   : active-low 7-segment patterns (g..a) for Qval/Rval nibbles
interface divider_8bit_if;
  logic       Load_Divisor;
  logic       Run;
  logic [7:0] S;
  logic [7:0] Qval;
  logic [7:0] Rval;
  logic [7:0] Dval;
  logic       Busy;
  logic       Done;
  logic       Div_Zero;
  logic       Overflow;
  logic [6:0] QhexL;
  logic [6:0] QhexU;
  logic [6:0] RhexL;
  logic [6:0] RhexU;

  modport master (
    output Load_Divisor, Run, S,
    input  Qval, Rval, Dval, Busy, Done, Div_Zero, Overflow,
    input  QhexL, QhexU, RhexL, RhexU
  );

  modport slave (
    input  Load_Divisor, Run, S,
    output Qval, Rval, Dval, Busy, Done, Div_Zero, Overflow,
    output QhexL, QhexU, RhexL, RhexU
  );
endinterface

// File: rtl/divider_8bit.sv
// Sequential 8-bit signed restoring divider.
// Divisor is loaded from S with Load_Divisor; Run captures the dividend from S
// and yields a truncating quotient and dividend-signed remainder 10 edges later.
// Divide-by-zero and -128/-1 are resolved in one edge with status flags.
// Ports:
//   Clk   : rising-edge clock
//   Reset : synchronous active-high reset
//   bus   : divider_8bit_if.slave (controls, switch data, results, flags, hex segments)
module divider_8bit #(
  parameter int unsigned ITER = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  divider_8bit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_t;

  state_t     state;
  logic [7:0] qval_r;
  logic [7:0] rval_r;
  logic [7:0] dval_r;
  logic       busy_r;
  logic       done_r;
  logic       dz_r;
  logic       ov_r;

  logic [7:0] q_work;
  logic [7:0] m_work;
  logic [8:0] p_work;
  logic [2:0] count;
  logic       sign_q;
  logic       sign_r;

  logic [8:0] p_shift;
  logic [8:0] trial;

  // One restoring step: bring the next dividend bit into P and trial-subtract M.
  always_comb begin
    p_shift = {p_work[7:0], q_work[7]};
    trial   = p_shift - {1'b0, m_work};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= ST_IDLE;
      qval_r <= '0;
      rval_r <= '0;
      dval_r <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      ov_r   <= 1'b0;
      q_work <= '0;
      m_work <= '0;
      p_work <= '0;
      count  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.Load_Divisor) begin
            dval_r <= bus.S;
            qval_r <= '0;
            rval_r <= '0;
            dz_r   <= 1'b0;
            ov_r   <= 1'b0;
          end else if (bus.Run) begin
            if (dval_r == 8'h00) begin
              qval_r <= '1;
              rval_r <= bus.S;
              dz_r   <= 1'b1;
              ov_r   <= 1'b0;
              done_r <= 1'b1;
              state  <= ST_DONE;
            end else if (bus.S == 8'h80 && dval_r == 8'hFF) begin
              qval_r <= 8'h80;
              rval_r <= '0;
              dz_r   <= 1'b0;
              ov_r   <= 1'b1;
              done_r <= 1'b1;
              state  <= ST_DONE;
            end else begin
              // Unsigned negate gives |-128| = 0x80, which the 8-bit datapath handles.
              q_work <= bus.S[7] ? -bus.S : bus.S;
              m_work <= dval_r[7] ? -dval_r : dval_r;
              p_work <= '0;
              sign_q <= bus.S[7] ^ dval_r[7];
              sign_r <= bus.S[7];
              dz_r   <= 1'b0;
              ov_r   <= 1'b0;
              count  <= '0;
              busy_r <= 1'b1;
              state  <= ST_ITER;
            end
          end
        end

        ST_ITER: begin
          if (!trial[8]) begin
            p_work <= trial;
            q_work <= {q_work[6:0], 1'b1};
          end else begin
            p_work <= p_shift;
            q_work <= {q_work[6:0], 1'b0};
          end
          count <= count + 3'd1;
          if (count == 3'(ITER - 1)) begin
            state <= ST_FIX;
          end
        end

        ST_FIX: begin
          qval_r <= sign_q ? -q_work : q_work;
          rval_r <= sign_r ? -p_work[7:0] : p_work[7:0];
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= ST_DONE;
        end

        ST_DONE: begin
          // Run is a level: wait for release so one assertion yields one division.
          if (!bus.Run) begin
            done_r <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] seg;
    unique case (n)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign bus.Qval     = qval_r;
  assign bus.Rval     = rval_r;
  assign bus.Dval     = dval_r;
  assign bus.Busy     = busy_r;
  assign bus.Done     = done_r;
  assign bus.Div_Zero = dz_r;
  assign bus.Overflow = ov_r;

  always_comb begin
    bus.QhexL = hex7(qval_r[3:0]);
    bus.QhexU = hex7(qval_r[7:4]);
    bus.RhexL = hex7(rval_r[3:0]);
    bus.RhexU = hex7(rval_r[7:4]);
  end

endmodule

// File: tb/tb_divider_8bit.sv
module tb_divider_8bit;

  logic clk = 1'b0;
  logic rst;

  divider_8bit_if bus ();

  divider_8bit #(.ITER(8)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] r;
    bit         dz;
    bit         ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed integer division (truncating, remainder follows dividend).
  function automatic exp_t ref_div(input logic [7:0] d, input logic [7:0] s);
    exp_t e;
    int di;
    int si;
    di = int'($signed(d));
    si = int'($signed(s));
    e.d  = d;
    e.dz = 1'b0;
    e.ov = 1'b0;
    if (di == 0) begin
      e.q  = 8'hFF;
      e.r  = s;
      e.dz = 1'b1;
    end else if (si == -128 && di == -1) begin
      e.q  = 8'h80;
      e.r  = 8'h00;
      e.ov = 1'b1;
    end else begin
      e.q = 8'(si / di);
      e.r = 8'(si % di);
    end
    return e;
  endfunction

  // Monitor: compare against the scoreboard each time Done rises.
  logic done_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.Done === 1'b1 && done_q !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: Done rose with no pending division, Qval=%0h", bus.Qval);
      end else begin
        e = sb.pop_front();
        chk("qval", bus.Qval, e.q);
        chk("rval", bus.Rval, e.r);
        chk("dval", bus.Dval, e.d);
        chk("div_zero", bus.Div_Zero, e.dz);
        chk("overflow", bus.Overflow, e.ov);
        chk("qhexl", bus.QhexL, seg_tab[e.q[3:0]]);
        chk("qhexu", bus.QhexU, seg_tab[e.q[7:4]]);
        chk("rhexl", bus.RhexL, seg_tab[e.r[3:0]]);
        chk("rhexu", bus.RhexU, seg_tab[e.r[7:4]]);
      end
    end
    done_q = bus.Done;
  end

  task automatic load_divisor(input logic [7:0] d);
    @(negedge clk);
    bus.Load_Divisor = 1'b1;
    bus.S            = d;
    @(negedge clk);
    bus.Load_Divisor = 1'b0;
    chk("dval_load", bus.Dval, d);
    chk("qval_load_clr", bus.Qval, 8'h00);
    chk("rval_load_clr", bus.Rval, 8'h00);
  endtask

  task automatic divide(input logic [7:0] d, input logic [7:0] s, input bit mid_load);
    exp_t e;
    bit   special;
    int   lat;
    int   hold;
    e = ref_div(d, s);
    load_divisor(d);
    special = e.dz || e.ov;
    lat  = special ? 1 : 10;
    hold = lat + 2 + int'($urandom_range(0, 4));
    bus.S   = s;
    bus.Run = 1'b1;
    sb.push_back(e);
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      chk("busy", bus.Busy, (!special && k < lat) ? 1 : 0);
      chk("done", bus.Done, (k >= lat) ? 1 : 0);
      if (mid_load && k == 4) begin
        bus.Load_Divisor = 1'b1;
        bus.S            = 8'h09;
      end else if (mid_load && k == 5) begin
        bus.Load_Divisor = 1'b0;
      end
    end
    chk("dval_hold", bus.Dval, d);
    bus.Run = 1'b0;
    @(negedge clk);
    chk("done_release", bus.Done, 0);
    chk("qval_retain", bus.Qval, e.q);
    chk("rval_retain", bus.Rval, e.r);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] s;
    rst              = 1'b1;
    bus.Load_Divisor = 1'b0;
    bus.Run          = 1'b0;
    bus.S            = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_qval", bus.Qval, 8'h00);
    chk("rst_rval", bus.Rval, 8'h00);
    chk("rst_dval", bus.Dval, 8'h00);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_dz", bus.Div_Zero, 0);
    chk("rst_ov", bus.Overflow, 0);
    chk("rst_qhexl", bus.QhexL, 7'b1000000);
    chk("rst_rhexu", bus.RhexU, 7'b1000000);
    rst = 1'b0;

    divide(8'h07, 8'h64, 1'b0);
    divide(8'h07, 8'h9C, 1'b0);
    divide(8'hF9, 8'h64, 1'b0);
    divide(8'hF9, 8'h9C, 1'b0);
    divide(8'h00, 8'h55, 1'b0);
    divide(8'hFF, 8'h80, 1'b0);
    divide(8'h01, 8'h80, 1'b0);
    divide(8'h07, 8'h64, 1'b1);

    // Reset on the 4th ITER edge abandons the division.
    load_divisor(8'h07);
    bus.S   = 8'h64;
    bus.Run = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_qval", bus.Qval, 8'h00);
    chk("midrst_rval", bus.Rval, 8'h00);
    chk("midrst_dval", bus.Dval, 8'h00);
    chk("midrst_busy", bus.Busy, 0);
    chk("midrst_done", bus.Done, 0);
    chk("midrst_qhexl", bus.QhexL, 7'b1000000);
    rst     = 1'b0;
    bus.Run = 1'b0;
    @(negedge clk);
    chk("midrst_idle_busy", bus.Busy, 0);
    divide(8'h03, 8'h0A, 1'b0);

    // Load_Divisor and Run together: load wins, division starts one edge later.
    @(negedge clk);
    bus.Load_Divisor = 1'b1;
    bus.Run          = 1'b1;
    bus.S            = 8'h05;
    sb.push_back(ref_div(8'h05, 8'h05));
    @(negedge clk);
    bus.Load_Divisor = 1'b0;
    chk("lr_dval", bus.Dval, 8'h05);
    chk("lr_busy", bus.Busy, 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("lr_done", bus.Done, (k >= 10) ? 1 : 0);
    end
    bus.Run = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) d = 8'h00;
      if ($urandom_range(0, 9) == 0) begin
        d = 8'hFF;
        s = 8'h80;
      end
      divide(d, s, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider_8bit.md
Name: divider_8bit

Overview:
- Sequential 8-bit signed (two's-complement) restoring divider, the inverse companion of the shift-add multiplier datapath.
- The divisor is loaded from the switches first. Run then captures the dividend from the switches and produces quotient and remainder in 10 cycles.
- Results are driven to the board hex displays through the team HexDriver.
- Control inputs arrive already debounced and active-high; board-level button inversion is done outside this block.

Parameters:
- ITER, 8, number of shift/subtract iterations; equals operand width, fixed at 8.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Load_Divisor  input  1  active-high level; loads S into the divisor register.
- Run  input  1  active-high level; starts a division.
- S  input  8  switch data: divisor on Load_Divisor, dividend on Run.
- Qval  output  8  quotient, signed.
- Rval  output  8  remainder, signed.
- Dval  output  8  stored divisor.
- Busy  output  1  high while a division is in progress.
- Done  output  1  high while results are valid and Run is still held.
- Div_Zero  output  1  last division had divisor 0.
- Overflow  output  1  last division was -128 / -1.
- QhexL, QhexU, RhexL, RhexU  output  7 each  active-low segments for the Qval/Rval nibbles.

Behaviour:
- Reset (synchronous, any state, including mid-division):
  - state goes to IDLE;
  - Qval, Rval, Dval = 0x00;
  - Busy, Done, Div_Zero, Overflow = 0;
  - internal counter and working registers cleared;
  - hex outputs show "0" (7'b1000000).
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - Load_Divisor=1: Dval<=S; Qval, Rval<=0; Div_Zero, Overflow<=0. Load_Divisor has priority over Run in the same cycle; Run is ignored that cycle and, being a level, is acted on the next cycle.
  - Run=1, Dval==0: Qval<=0xFF; Rval<=S; Div_Zero<=1; go to DONE. Done is high one edge after Run is sampled.
  - Run=1, S==0x80 and Dval==0xFF: Qval<=0x80; Rval<=0x00; Overflow<=1; go to DONE.
  - Run=1, otherwise:
    - capture dividend magnitude |S| into working Q, divisor magnitude |Dval| into working M;
    - clear 9-bit partial remainder P;
    - latch sign_q = S[7]^Dval[7] and sign_r = S[7];
    - clear Div_Zero and Overflow; count<=0; Busy<=1; go to ITER.
  - Magnitudes are 8-bit unsigned, so |−128| = 128 = 0x80.
- ITER, one iteration per cycle, 8 cycles:
  - shift {P,Q} left one bit;
  - T = P_shifted − {0,M} in 9 bits;
  - if T[8]==0: P<=T, Q[0]<=1; else P unchanged, Q[0]<=0;
  - count increments; after count reaches 7, go to FIX.
- FIX:
  - Qval <= sign_q ? −Q : Q;
  - Rval <= sign_r ? −P[7:0] : P[7:0];
  - Busy<=0; Done<=1; go to DONE.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend (identity: dividend = Qval·Dval + Rval).
- Latency: Done rises on the 10th rising edge counting the edge that samples Run (1 start + 8 ITER + 1 FIX).
- DONE:
  - holds all outputs;
  - Load_Divisor and Run-level restarts are ignored;
  - when Run=0: Done<=0, go to IDLE, Qval and Rval retained.
  - One Run assertion yields exactly one division regardless of hold time.
- Load_Divisor and S changes during ITER/FIX have no effect. Qval/Rval change only in FIX or on the IDLE special cases.
- Hex outputs are combinational decode of Qval/Rval nibbles: 0–F, active-low, segment order g..a.

Test Plan:
- Load_Divisor with S=0x07, then Run with S=0x64 (100) held 20 cycles -> Done on edge 10; Qval=0x0E, Rval=0x02; Busy high on edges 1–9; Done stays high until Run drops, then Qval/Rval are retained.
- Signed mixes with Dval=0x07 and S=0x9C (−100) -> Qval=0xF2, Rval=0xFE. With Dval=0xF9 (−7) and S=0x64 -> Qval=0xF2, Rval=0x02. With Dval=0xF9 and S=0x9C -> Qval=0x0E, Rval=0xFE.
- Boundaries:
  - Dval=0x00, S=0x55 -> Div_Zero=1, Qval=0xFF, Rval=0x55, Done after 1 edge.
  - Dval=0xFF, S=0x80 -> Overflow=1, Qval=0x80, Rval=0x00.
  - Dval=0x01, S=0x80 -> Qval=0x80, Rval=0x00, no flags.
- Reset asserted on the 4th ITER cycle -> next edge all outputs 0, state IDLE. A subsequent load of 0x03 and Run with 0x0A gives Qval=0x03, Rval=0x01.
- Load_Divisor and Run asserted together in IDLE with S=0x05 -> Dval=0x05 on edge 1, division starts on edge 2, Qval=0x01, Rval=0x00. Load_Divisor pulsed mid-ITER with S=0x09 -> Dval unchanged.
- Hex check: Qval=0x0E -> QhexU=7'b1000000, QhexL=7'b0000110.
